nco_sweep_ctrl: RTL and testbench
=================================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter APR, default 32: phase-increment width, matching the NCO phi_inc_i width.
REQ-002 SHALL have parameter DWW, default 16: dwell-counter width.
REQ-003 SHALL have parameter LAT, default 10: NCO pipeline latency, in enabled cycles.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begin a sweep; honoured only in IDLE.
REQ-007 SHALL have port abort, input, 1 bit: terminate the sweep.
REQ-008 SHALL have port hold, input, 1 bit: freeze the sweep and the NCO.
REQ-009 SHALL have port mode, input, 2 bits: 0 = single up, 1 = repeat, 2 = triangle, 3 = treated as 0.
REQ-010 SHALL have ports f_start, f_stop and f_step, input, APR bits each: sweep start, stop and step increments.
REQ-011 SHALL have port dwell, input, DWW bits: cycles spent at each frequency; 0 is treated as 1.
REQ-012 SHALL have port phi_inc_o, output, APR bits: drives the NCO phi_inc_i.
REQ-013 SHALL have port nco_clken_o, output, 1 bit: drives the NCO clken.
REQ-014 SHALL have port busy, output, 1 bit: high in LOAD, DWELL and STEP.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port step_stb, output, 1 bit: one-cycle pulse when phi_inc_o changes.
REQ-017 SHALL have port settled, output, 1 bit: NCO output reflects the current phi_inc_o.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DWELL, STEP and DONE.
REQ-019 IDLE: start=1 SHALL latch mode, f_start, f_stop, f_step and dwell, then go to LOAD; later input changes SHALL be ignored until the next IDLE.
REQ-020 LOAD (1 cycle): phi_inc_o <= f_start, direction <= up, dwell counter <= max(dwell,1)-1, step_stb=1, then go to DWELL.
REQ-021 DWELL: the counter SHALL decrement once per non-hold cycle; when the counter is 0 and hold=0, the FSM SHALL go to STEP.
REQ-022 STEP, up direction: the (APR+1)-bit sum s = phi + f_step SHALL be computed.
  - If phi already equals f_stop, this is the endpoint.
  - Otherwise phi <= min(s, f_stop), step_stb=1, counter reloaded, return to DWELL.
REQ-023 STEP, down direction (mode 2 only): the difference d = phi - f_step SHALL be computed.
  - If phi equals f_start, this is the endpoint.
  - Otherwise phi <= max(d, f_start), with borrow treated as underflow, meaning f_start; step_stb=1, counter reloaded, return to DWELL.
REQ-024 Endpoint handling SHALL depend on mode.
  - Mode 0/3: go to DONE; phi_inc_o holds its value.
  - Mode 1 at up endpoint: phi <= f_start, step_stb=1 (if f_start != f_stop), return to DWELL.
  - Mode 2: reverse direction, then apply the step rule of the new direction in the same cycle.
REQ-025 If f_stop <= f_start, the sweep SHALL consist only of f_start.
  - Mode 0: a single dwell, then DONE.
  - Modes 1/2: dwell on f_start indefinitely, with no step_stb after LOAD.
REQ-026 If f_step = 0 and f_start < f_stop, the controller SHALL clamp f_step to 1.
REQ-027 DONE (1 cycle): done=1, busy=0, then go to IDLE.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and phi_inc_o unchanged; abort SHALL take priority over hold and start.
REQ-029 hold=1 SHALL freeze the FSM, the counter and phi_inc_o; nco_clken_o SHALL be the registered value of !hold, one cycle after hold changes.
REQ-030 nco_clken_o SHALL be 1 whenever hold=0, including in IDLE, so the NCO free-runs.
REQ-031 Settle counter behaviour:
  - SHALL load LAT+1 on every step_stb.
  - SHALL decrement on cycles where nco_clken_o=1.
  - settled = (settle counter == 0).
  - Registered outputs SHALL have 1 cycle latency from state to output.

Reset
REQ-032 reset=1 SHALL give, at the next edge: state IDLE, phi_inc_o=0, nco_clken_o=1, busy=0, done=0, step_stb=0, settled=0 and settle counter=LAT+1.
REQ-033 reset SHALL override start, abort and hold; reset mid-sweep SHALL abandon the sweep without a done pulse.

Verification
REQ-034 Mode 0 sweep:
  - Stimulus: f_start=100, f_stop=400, f_step=100, dwell=3.
  - Response: phi_inc_o = 100, 200, 300, 400, each for 3 DWELL cycles plus 1 STEP cycle.
  - Then one done pulse; busy falls; phi_inc_o stays 400.
REQ-035 Clamp and triangle:
  - Stimulus: f_start=0, f_stop=250, f_step=100, mode 2, dwell=1.
  - Response: phi sequence 0, 100, 200, 250, 150, 50, 0, 100, ...; no done.
REQ-036 Wrap-safe add:
  - Stimulus: f_start=32'hFFFF_FF00, f_stop=32'hFFFF_FFFF, f_step=32'h200.
  - Response: next phi = 32'hFFFF_FFFF, with no wrap to a small value.
REQ-037 Hold in DWELL:
  - Stimulus: assert hold=1 for 5 cycles mid-dwell.
  - Response: nco_clken_o=0 for 5 cycles, delayed by 1; the dwell is extended by exactly 5 cycles; settle counter frozen.
REQ-038 Abort:
  - Stimulus: abort mid-mode-1 sweep at phi=200.
  - Response: IDLE next cycle; phi_inc_o=200; done never asserted; an immediate new start is accepted.
REQ-039 Settling and degenerate range:
  - settled falls on the cycle after each step_stb and rises exactly LAT+1 enabled cycles later.
  - Stimulus: f_stop < f_start, mode 0.
  - Response: one dwell at f_start, then done.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller for an NCO: steps phi_inc_o from f_start to f_stop,
// dwelling a programmable number of cycles at each frequency, with hold/abort control.
module nco_sweep_ctrl #(
    parameter int APR = 32,
    parameter int DWW = 16,
    parameter int LAT = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic           hold,
    input  logic [1:0]     mode,
    input  logic [APR-1:0] f_start,
    input  logic [APR-1:0] f_stop,
    input  logic [APR-1:0] f_step,
    input  logic [DWW-1:0] dwell,
    output logic [APR-1:0] phi_inc_o,
    output logic           nco_clken_o,
    output logic           busy,
    output logic           done,
    output logic           step_stb,
    output logic           settled,
    output logic [2:0]     dbg_state_o
);

    localparam int SW = $clog2(LAT + 2);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DWELL = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_q;
    logic [1:0]     mode_q;
    logic [APR-1:0] f_start_q;
    logic [APR-1:0] f_stop_q;
    logic [APR-1:0] f_step_q;
    logic [DWW-1:0] reload_q;
    logic [DWW-1:0] cnt_q;
    logic           degen_q;
    logic           dir_dn_q;
    logic [APR-1:0] phi_q;
    logic           stb_q;
    logic           done_q;
    logic           busy_q;
    logic           clken_q;
    logic [SW-1:0]  settle_q;

    // One extra bit on both sides so a carry or borrow is never lost.
    logic [APR:0]   up_sum_d;
    logic [APR:0]   dn_diff_d;
    logic [APR-1:0] up_next_d;
    logic [APR-1:0] dn_next_d;
    logic           at_stop_d;
    logic           at_start_d;

    assign up_sum_d   = {1'b0, phi_q} + {1'b0, f_step_q};
    assign dn_diff_d  = {1'b0, phi_q} - {1'b0, f_step_q};
    assign up_next_d  = (up_sum_d > {1'b0, f_stop_q}) ? f_stop_q : up_sum_d[APR-1:0];
    assign dn_next_d  = (dn_diff_d[APR] || (dn_diff_d[APR-1:0] < f_start_q))
                        ? f_start_q : dn_diff_d[APR-1:0];
    assign at_stop_d  = (phi_q == f_stop_q);
    assign at_start_d = (phi_q == f_start_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            reload_q  <= '0;
            cnt_q     <= '0;
            degen_q   <= 1'b0;
            dir_dn_q  <= 1'b0;
            phi_q     <= '0;
            stb_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            clken_q   <= 1'b1;
            settle_q  <= SETTLE_INIT;
        end else begin
            clken_q <= !hold;
            busy_q  <= (state_q == S_LOAD) || (state_q == S_DWELL) || (state_q == S_STEP);
            stb_q   <= 1'b0;
            done_q  <= 1'b0;

            // Settle counter only advances while the NCO is actually clocked.
            if (stb_q)
                settle_q <= SETTLE_INIT;
            else if (clken_q && (settle_q != '0))
                settle_q <= settle_q - SW'(1);

            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
            end else if (!hold) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            mode_q    <= (mode == 2'd3) ? 2'd0 : mode;
                            f_start_q <= f_start;
                            f_stop_q  <= f_stop;
                            f_step_q  <= (f_step == '0) ? APR'(1) : f_step;
                            reload_q  <= (dwell == '0) ? '0 : dwell - DWW'(1);
                            degen_q   <= (f_stop <= f_start);
                            state_q   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        phi_q    <= f_start_q;
                        dir_dn_q <= 1'b0;
                        cnt_q    <= reload_q;
                        stb_q    <= 1'b1;
                        state_q  <= S_DWELL;
                    end
                    S_DWELL: begin
                        if (cnt_q == '0)
                            state_q <= S_STEP;
                        else
                            cnt_q <= cnt_q - DWW'(1);
                    end
                    S_STEP: begin
                        cnt_q   <= reload_q;
                        state_q <= S_DWELL;
                        if (degen_q) begin
                            // Empty range: sit on f_start; only single-shot mode ever finishes.
                            if (mode_q == 2'd0)
                                state_q <= S_DONE;
                        end else if (!dir_dn_q) begin
                            if (!at_stop_d) begin
                                phi_q <= up_next_d;
                                stb_q <= 1'b1;
                            end else if (mode_q == 2'd1) begin
                                phi_q <= f_start_q;
                                stb_q <= 1'b1;
                            end else if (mode_q == 2'd2) begin
                                dir_dn_q <= 1'b1;
                                phi_q    <= dn_next_d;
                                stb_q    <= 1'b1;
                            end else begin
                                state_q <= S_DONE;
                            end
                        end else begin
                            if (!at_start_d) begin
                                phi_q <= dn_next_d;
                            end else begin
                                dir_dn_q <= 1'b0;
                                phi_q    <= up_next_d;
                            end
                            stb_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign phi_inc_o   = phi_q;
    assign nco_clken_o = clken_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign step_stb    = stb_q;
    assign settled     = (settle_q == '0);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: builds the expected per-cycle output trace from the sweep
// rules (frequency list, dwell period, hold stretching, abort truncation) and compares.
module tb_nco_sweep_ctrl;

    localparam int APR = 32;
    localparam int DWW = 16;
    localparam int LAT = 10;

    logic           clk = 1'b0;
    logic           reset, start, abort, hold;
    logic [1:0]     mode;
    logic [APR-1:0] f_start, f_stop, f_step;
    logic [DWW-1:0] dwell;
    logic [APR-1:0] phi_inc_o;
    logic           nco_clken_o, busy, done, step_stb, settled;
    logic [2:0]     dbg_state_o;

    typedef struct packed {
        logic [APR-1:0] phi;
        logic           stb;
        logic           busy;
        logic           done;
    } ent_t;

    ent_t           exp_q[$];
    longint         fq[$];
    int             n_tests = 0;
    int             n_fail  = 0;
    int             en_cnt  = 0;
    logic [APR-1:0] cur_phi = '0;

    always #5 clk = ~clk;

    nco_sweep_ctrl #(.APR(APR), .DWW(DWW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
        .mode(mode), .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .phi_inc_o(phi_inc_o), .nco_clken_o(nco_clken_o), .busy(busy), .done(done),
        .step_stb(step_stb), .settled(settled), .dbg_state_o(dbg_state_o)
    );

    function automatic ent_t mk(input logic [APR-1:0] phi, input logic stb, input logic bz,
                                input logic dn);
        ent_t e;
        e.phi = phi; e.stb = stb; e.busy = bz; e.done = dn;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: compare all outputs, then advance the settle model.
    task automatic step_check(input ent_t e);
        logic e_clk;
        e_clk = !hold;
        tick();
        chk("phi_inc_o", 64'(phi_inc_o), 64'(e.phi));
        chk("step_stb", 64'(step_stb), 64'(e.stb));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("done", 64'(done), 64'(e.done));
        chk("nco_clken_o", 64'(nco_clken_o), 64'(e_clk));
        chk("settled", 64'(settled), 64'(en_cnt >= LAT + 1));
        if (e.stb) en_cnt = 0;
        else if (e_clk) en_cnt++;
    endtask

    // Frequency list visited by a sweep, from the stepping rules in plain arithmetic.
    task automatic gen_freqs(input longint st, input longint sp, input longint stp,
                             input int md, input int maxn);
        longint f, s;
        bit     up;
        fq.delete();
        s  = (stp == 0) ? 1 : stp;
        f  = st;
        up = 1'b1;
        fq.push_back(f);
        if (sp <= st) begin
            if (md == 1 || md == 2)
                while (fq.size() < maxn) fq.push_back(st);
            return;
        end
        while (fq.size() < maxn) begin
            if (up) begin
                if (f == sp) begin
                    if (md == 1) f = st;
                    else if (md == 2) begin
                        up = 1'b0;
                        f  = (f - s < st) ? st : f - s;
                    end else return;
                end else f = (f + s > sp) ? sp : f + s;
            end else begin
                if (f == st) begin
                    up = 1'b1;
                    f  = (f + s > sp) ? sp : f + s;
                end else f = (f - s < st) ? st : f - s;
            end
            fq.push_back(f);
        end
    endtask

    task automatic run_sweep(input logic [APR-1:0] st, input logic [APR-1:0] sp,
                             input logic [APR-1:0] stp, input logic [1:0] md,
                             input logic [DWW-1:0] dw, input int hold_at, input int hold_len,
                             input int abort_at, input bit ab_hold);
        int   p, n, j;
        ent_t e;
        bit   fin;
        fin = !(md == 2'd1 || md == 2'd2);
        p   = ((dw == '0) ? 1 : int'(dw)) + 1;
        gen_freqs(longint'(st), longint'(sp), longint'(stp), int'(md),
                  fin ? (1 << 20) : (abort_at / p + 3));
        n = fq.size();
        exp_q.delete();
        exp_q.push_back(mk(cur_phi, 1'b0, 1'b0, 1'b0));
        for (int k = 2; k < 2 + n * p; k++) begin
            j = (k - 2) / p;
            exp_q.push_back(mk(APR'(fq[j]),
                               ((k - 2) % p == 0) && (j == 0 || fq[j] != fq[j-1]), 1'b1, 1'b0));
        end
        if (fin) begin
            exp_q.push_back(mk(APR'(fq[n-1]), 1'b0, 1'b1, 1'b0));
            exp_q.push_back(mk(APR'(fq[n-1]), 1'b0, 1'b0, 1'b1));
            exp_q.push_back(mk(APR'(fq[n-1]), 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(APR'(fq[n-1]), 1'b0, 1'b0, 1'b0));
        end
        // A hold freezes everything: the held cycle repeats, minus any pulse.
        if (hold_len > 0) begin
            e = exp_q[hold_at-1];
            e.stb = 1'b0;
            e.done = 1'b0;
            for (int i = 0; i < hold_len; i++) exp_q.insert(hold_at, e);
        end
        if (abort_at > 0) begin
            while (exp_q.size() > abort_at) void'(exp_q.pop_back());
            exp_q.push_back(mk(exp_q[abort_at-1].phi, 1'b0, 1'b1, 1'b0));
        end

        mode = md; f_start = st; f_stop = sp; f_step = stp; dwell = dw; start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            step_check(exp_q[i]);
            mode = 2'($urandom); f_start = $urandom; f_stop = $urandom;
            f_step = $urandom; dwell = DWW'($urandom);
            start = (i + 1 < exp_q.size() && exp_q[i+1].busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (hold_len > 0 && i + 1 == hold_at) hold = 1'b1;
            if (hold_len > 0 && i + 1 == hold_at + hold_len) hold = 1'b0;
            if (abort_at > 0) begin
                abort = (i + 1 == abort_at);
                if (i + 1 == abort_at) begin
                    hold  = ab_hold;
                    start = 1'b1;
                end
                if (i + 1 == abort_at + 1) hold = 1'b0;
            end
        end
        start   = 1'b0;
        abort   = 1'b0;
        cur_phi = exp_q[exp_q.size()-1].phi;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
        hold  = 1'($urandom_range(0, 1));
        tick();
        start = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
        hold  = 1'($urandom_range(0, 1));
        tick();
        chk("rst_phi", 64'(phi_inc_o), 64'(0));
        chk("rst_clken", 64'(nco_clken_o), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_stb", 64'(step_stb), 64'(0));
        chk("rst_settled", 64'(settled), 64'(0));
        reset = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
        cur_phi = '0;
        en_cnt  = 1;
    endtask

    initial begin
        logic [APR-1:0] base, st, sp, stp;
        logic [1:0]     md;
        logic [DWW-1:0] dw;
        int             p;

        reset = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
        mode = '0; f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
        do_reset();

        // Idle: NCO free-runs, a hold only gates the clock enable.
        hold = 1'b1;
        step_check(mk(cur_phi, 1'b0, 1'b0, 1'b0));
        hold = 1'b0;
        repeat (LAT + 3) step_check(mk(cur_phi, 1'b0, 1'b0, 1'b0));

        run_sweep(100, 400, 100, 2'd0, 3, 0, 0, 0, 1'b0);
        run_sweep(100, 400, 100, 2'd3, 3, 7, 5, 0, 1'b0);
        run_sweep(0, 250, 100, 2'd2, 1, 0, 0, 22, 1'b0);

        dw = DWW'($urandom_range(1, 4));
        p  = int'(dw) + 1;
        run_sweep(100, 400, 100, 2'd1, dw, 0, 0, 2 + p + $urandom_range(0, p - 1), 1'b1);
        run_sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 2'd0, DWW'($urandom_range(0, 3)),
                  0, 0, 0, 1'b0);

        run_sweep(500, 300, 7, 2'd0, 2, 0, 0, 0, 1'b0);
        run_sweep(77, 77, 1, 2'd3, 0, 0, 0, 0, 1'b0);
        run_sweep(900, 20, 5, 2'd1, 1, 0, 0, 9, 1'b0);
        run_sweep(900, 900, 5, 2'd2, 2, 0, 0, 10, 1'b1);
        run_sweep(5, 8, 0, 2'd0, 0, 0, 0, 0, 1'b0);

        // Reset in the middle of a sweep: no done pulse may follow.
        mode = 2'd0; f_start = 10; f_stop = 1000; f_step = 10; dwell = 2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat ($urandom_range(3, 20)) tick();
        do_reset();
        repeat (4) step_check(mk(cur_phi, 1'b0, 1'b0, 1'b0));

        for (int r = 0; r < 16; r++) begin
            base = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FF00 : 32'h0;
            st   = base + APR'($urandom_range(0, 100));
            sp   = base + APR'($urandom_range(0, 255));
            stp  = APR'($urandom_range(0, 200));
            md   = 2'($urandom_range(0, 3));
            dw   = DWW'($urandom_range(0, 4));
            p    = ((dw == '0) ? 1 : int'(dw)) + 1;
            if (md == 2'd1 || md == 2'd2)
                run_sweep(st, sp, stp, md, dw, 0, 0, $urandom_range(2, 60),
                          1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 1) == 1)
                run_sweep(st, sp, stp, md, dw, $urandom_range(3, 1 + p),
                          $urandom_range(1, 6), 0, 1'b0);
            else
                run_sweep(st, sp, stp, md, dw, 0, 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
